// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_ctrl data-memory responder.
package dmem_pkg;

  localparam int DMEM_NUM_THREADS = 4;
  localparam int DMEM_DATA_WIDTH  = 16;
  localparam int DMEM_ADDR_WIDTH  = 8;
  localparam int THREAD_IDX_WIDTH = $clog2(DMEM_NUM_THREADS);

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic                       valid;
    logic                       is_write;
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [DMEM_DATA_WIDTH-1:0] data;
  } slot_t;

endpackage

// File: rtl/dmem_ctrl_rr_arbiter.sv
// Round-robin pick of the first requesting channel at or above rr_ptr, wrapping.
module rr_arbiter
  import dmem_pkg::*;
#(
  parameter  int NUM_THREADS = DMEM_NUM_THREADS,
  localparam int IDXW        = idx_width(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] req,
  input  logic [IDXW-1:0]        rr_ptr,
  output logic [IDXW-1:0]        grant,
  output logic                   any_grant
);

  logic [IDXW-1:0] idx;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      idx = IDXW'((int'(rr_ptr) + k) % NUM_THREADS);
      if (!any_grant && req[idx]) begin
        grant     = idx;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-channel LSU data-memory responder with one access in flight at a time.
// Optional host backdoor port enabled by defining DMEM_CTRL_HOST_PORT_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int NUM_THREADS     = DMEM_NUM_THREADS,
  parameter int DATA_WIDTH      = DMEM_DATA_WIDTH,
  parameter int DATA_ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int MEM_DEPTH       = 256,
  parameter int MEM_LATENCY     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef DMEM_CTRL_HOST_PORT_EN
  input  logic                       host_we,
  input  logic [DATA_ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]      host_wdata,
  output logic [DATA_WIDTH-1:0]      host_rdata,
`endif
  output logic                       read_req_rdy       [NUM_THREADS],
  input  logic [DATA_ADDR_WIDTH-1:0] read_req_addr      [NUM_THREADS],
  input  logic                       read_req_addr_val  [NUM_THREADS],
  input  logic                       read_resp_rdy      [NUM_THREADS],
  output logic [DATA_WIDTH-1:0]      read_resp_data     [NUM_THREADS],
  output logic                       read_resp_data_val [NUM_THREADS],
  output logic                       write_req_rdy      [NUM_THREADS],
  input  logic [DATA_ADDR_WIDTH-1:0] write_req_addr     [NUM_THREADS],
  input  logic [DATA_WIDTH-1:0]      write_req_data     [NUM_THREADS],
  input  logic                       write_req_val      [NUM_THREADS],
  output logic                       write_resp_val     [NUM_THREADS]
);

  localparam int IDXW  = idx_width(NUM_THREADS);
  localparam int MIDXW = idx_width(MEM_DEPTH);
  localparam int CNTW  = idx_width(MEM_LATENCY);

  state_t                     state, next_state;
  logic [IDXW-1:0]            rr_ptr, g, arb_grant;
  logic                       arb_any;
  logic [CNTW-1:0]            cnt;
  slot_t                      pending   [NUM_THREADS];
  logic [DATA_WIDTH-1:0]      resp_data [NUM_THREADS];
  logic [DATA_WIDTH-1:0]      mem       [MEM_DEPTH];
  logic [NUM_THREADS-1:0]     req_vec;
  logic                       start_grant, do_access, do_complete;
  logic                       cur_is_write;
  logic [DATA_ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]      cur_data, rd_word;
  logic                       lsu_wr, host_wr, host_block;
  logic [MIDXW-1:0]           host_idx;
  logic [DATA_WIDTH-1:0]      host_data;

  function automatic logic in_range(input logic [DATA_ADDR_WIDTH-1:0] a);
    return int'(a) < MEM_DEPTH;
  endfunction

  assign cur_is_write = pending[g].is_write;
  assign cur_addr     = pending[g].addr;
  assign cur_data     = pending[g].data;
  assign rd_word      = in_range(cur_addr) ? mem[cur_addr[MIDXW-1:0]] : '0;
  assign lsu_wr       = do_access && cur_is_write && in_range(cur_addr);

`ifdef DMEM_CTRL_HOST_PORT_EN
  assign host_block = host_we;
  assign host_wr    = host_we && in_range(host_addr);
  assign host_idx   = host_addr[MIDXW-1:0];
  assign host_data  = host_wdata;
  assign host_rdata = in_range(host_addr) ? mem[host_addr[MIDXW-1:0]] : '0;
`else
  assign host_block = 1'b0;
  assign host_wr    = 1'b0;
  assign host_idx   = '0;
  assign host_data  = '0;
`endif

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM_THREADS; i++) req_vec[i] = pending[i].valid;
  end

  rr_arbiter #(.NUM_THREADS(NUM_THREADS)) u_arb (
    .req       (req_vec),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .any_grant (arb_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // A read stays in RESP until the LSU takes it; a write ack is a single cycle.
  always_comb begin
    next_state  = state;
    start_grant = 1'b0;
    do_access   = 1'b0;
    do_complete = 1'b0;
    case (state)
      IDLE: if (arb_any && !host_block) begin
        start_grant = 1'b1;
        next_state  = BUSY;
      end
      BUSY: if (cnt == '0) begin
        do_access  = 1'b1;
        next_state = RESP;
      end
      RESP: if (cur_is_write || read_resp_rdy[g]) begin
        do_complete = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      g      <= '0;
      cnt    <= '0;
    end else if (start_grant) begin
      g      <= arb_grant;
      rr_ptr <= (arb_grant == IDXW'(NUM_THREADS - 1)) ? '0 : arb_grant + 1'b1;
      cnt    <= CNTW'(MEM_LATENCY - 1);
    end else if (state == BUSY && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_chan
    // Read wins over a simultaneous write; the write simply stays offered.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pending[i]   <= '0;
        resp_data[i] <= '0;
      end else begin
        if (!pending[i].valid) begin
          if (read_req_addr_val[i])
            pending[i] <= '{1'b1, 1'b0, read_req_addr[i], '0};
          else if (write_req_val[i])
            pending[i] <= '{1'b1, 1'b1, write_req_addr[i], write_req_data[i]};
        end else if (do_complete && g == IDXW'(i)) begin
          pending[i].valid <= 1'b0;
        end
        if (do_access && !cur_is_write && g == IDXW'(i)) resp_data[i] <= rd_word;
      end
    end

    assign read_req_rdy[i]       = reset && !pending[i].valid;
    assign write_req_rdy[i]      = reset && !pending[i].valid;
    assign read_resp_data[i]     = resp_data[i];
    assign read_resp_data_val[i] = (state == RESP) && (g == IDXW'(i)) && !pending[i].is_write;
    assign write_resp_val[i]     = (state == RESP) && (g == IDXW'(i)) && pending[i].is_write;
  end

  // Host write is checked first so it overrides a same-cycle LSU write.
  for (genvar j = 0; j < MEM_DEPTH; j++) begin : g_word
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                       mem[j] <= '0;
      else if (host_wr && host_idx == MIDXW'(j))        mem[j] <= host_data;
      else if (lsu_wr && cur_addr[MIDXW-1:0] == MIDXW'(j)) mem[j] <= cur_data;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: per-channel expectation queues filled at request
// time and drained by a response monitor; MEM_DEPTH=128 to exercise out-of-range.
module tb_dmem_ctrl;

  localparam int NT    = 4;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  typedef struct packed {
    logic          is_write;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          read_req_rdy       [NT];
  logic [AW-1:0] read_req_addr      [NT];
  logic          read_req_addr_val  [NT];
  logic          read_resp_rdy      [NT];
  logic [DW-1:0] read_resp_data     [NT];
  logic          read_resp_data_val [NT];
  logic          write_req_rdy      [NT];
  logic [AW-1:0] write_req_addr     [NT];
  logic [DW-1:0] write_req_data     [NT];
  logic          write_req_val      [NT];
  logic          write_resp_val     [NT];

  exp_t sb [NT][$];
  int   done_order[$];
  int   errors = 0;
  int   checks = 0;
  exp_t mon_e;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .NUM_THREADS(NT), .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW),
    .MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .read_req_rdy(read_req_rdy), .read_req_addr(read_req_addr),
    .read_req_addr_val(read_req_addr_val), .read_resp_rdy(read_resp_rdy),
    .read_resp_data(read_resp_data), .read_resp_data_val(read_resp_data_val),
    .write_req_rdy(write_req_rdy), .write_req_addr(write_req_addr),
    .write_req_data(write_req_data), .write_req_val(write_req_val),
    .write_resp_val(write_resp_val)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // A response completes on the edge after a negedge showing it (read needs rdy).
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NT; i++) begin
        if (write_resp_val[i] || (read_resp_data_val[i] && read_resp_rdy[i])) begin
          if (sb[i].size() == 0) begin
            check_output($sformatf("unexpected_resp_ch%0d", i), 1, 0);
          end else begin
            mon_e = sb[i].pop_front();
            check_output($sformatf("resp_kind_ch%0d", i), write_resp_val[i], mon_e.is_write);
            if (!mon_e.is_write)
              check_output($sformatf("resp_data_ch%0d", i), read_resp_data[i], mon_e.data);
          end
          done_order.push_back(i);
        end
      end
    end
  end

  task automatic send_req(input logic [1:0] ch, input bit w, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_d);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    if (w) begin
      write_req_addr[ch] = addr;
      write_req_data[ch] = wdata;
      write_req_val[ch]  = 1'b1;
    end else begin
      read_req_addr[ch]     = addr;
      read_req_addr_val[ch] = 1'b1;
    end
    while (n < 50) begin
      @(negedge clk);
      if (w ? write_req_rdy[ch] : read_req_rdy[ch]) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    check_output($sformatf("accept_ch%0d", ch), ok, 1);
    if (ok) sb[ch].push_back('{is_write: w, data: exp_d});
    @(posedge clk);
    #1;
    write_req_val[ch]     = 1'b0;
    read_req_addr_val[ch] = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_drained"}, sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NT; i++) begin
      check_output($sformatf("%s_rrdy%0d", tag, i), read_req_rdy[i], 0);
      check_output($sformatf("%s_wrdy%0d", tag, i), write_req_rdy[i], 0);
      check_output($sformatf("%s_rval%0d", tag, i), read_resp_data_val[i], 0);
      check_output($sformatf("%s_rdata%0d", tag, i), read_resp_data[i], 0);
      check_output($sformatf("%s_wval%0d", tag, i), write_resp_val[i], 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   lat;
    int   n;
    logic fin [NT];
    logic all_fin;

    for (int i = 0; i < NT; i++) begin
      read_req_addr[i] = '0;  read_req_addr_val[i] = 1'b0; read_resp_rdy[i] = 1'b1;
      write_req_addr[i] = '0; write_req_data[i] = '0;      write_req_val[i] = 1'b0;
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_reset_rdy0", read_req_rdy[0], 1);

    $display("[TB] single write then read on ch1");
    send_req(2'd1, 1'b1, 8'h10, 16'hBEEF, 16'h0);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (write_resp_val[1]) break;
      @(posedge clk);
      lat++;
    end
    check_output("t1_write_latency", lat, 3);
    wait_drain("t1w");
    send_req(2'd1, 1'b0, 8'h10, 16'h0, 16'hBEEF);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (read_resp_data_val[1]) break;
      @(posedge clk);
      lat++;
    end
    check_output("t1_read_latency", lat, 3);
    wait_drain("t1r");

    $display("[TB] preload 0xA0..0xA3 via ch3");
    for (int k = 0; k < 4; k++)
      send_req(2'd3, 1'b1, AW'(k), DW'(16'hA0 + k), 16'h0);
    wait_drain("preload");

    $display("[TB] four-way contention");
    done_order.delete();
    for (int k = 0; k < NT; k++) begin
      read_req_addr[k]     = AW'(k);
      read_req_addr_val[k] = 1'b1;
      sb[k].push_back('{is_write: 1'b0, data: DW'(16'hA0 + k)});
      fin[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NT; k++) read_req_addr_val[k] = 1'b0;
    n = 0;
    all_fin = 1'b0;
    while (!all_fin && n < 40) begin
      @(negedge clk);
      all_fin = 1'b1;
      for (int k = 0; k < NT; k++) begin
        check_output($sformatf("t2_rdy_ch%0d", k), read_req_rdy[k], fin[k]);
        if (read_resp_data_val[k]) fin[k] = 1'b1;
        all_fin = all_fin && fin[k];
      end
      n++;
    end
    wait_drain("t2");
    check_output("t2_order_len", done_order.size(), 4);
    for (int k = 0; k < NT; k++)
      if (k < done_order.size()) check_output($sformatf("t2_order%0d", k), done_order[k], k);

    $display("[TB] backpressure on ch2");
    read_resp_rdy[2] = 1'b0;
    send_req(2'd2, 1'b0, 8'h02, 16'h0, 16'hA2);
    send_req(2'd0, 1'b0, 8'h03, 16'h0, 16'hA3);
    n = 0;
    while (!read_resp_data_val[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("t3_val_seen", read_resp_data_val[2], 1);
    repeat (5) begin
      @(negedge clk);
      check_output("t3_hold_val", read_resp_data_val[2], 1);
      check_output("t3_hold_data", read_resp_data[2], 16'hA2);
      check_output("t3_no_other", read_resp_data_val[0], 0);
    end
    @(posedge clk);
    #1;
    read_resp_rdy[2] = 1'b1;
    wait_drain("t3");
    check_output("t3_idle_rdy2", read_req_rdy[2], 1);
    check_output("t3_idle_rdy0", read_req_rdy[0], 1);

    $display("[TB] simultaneous read and write on ch0");
    read_req_addr[0]     = 8'h05;
    read_req_addr_val[0] = 1'b1;
    write_req_addr[0]    = 8'h05;
    write_req_data[0]    = 16'h1234;
    write_req_val[0]     = 1'b1;
    sb[0].push_back('{is_write: 1'b0, data: 16'h0});
    sb[0].push_back('{is_write: 1'b1, data: 16'h0});
    @(posedge clk);
    #1;
    read_req_addr_val[0] = 1'b0;
    @(negedge clk);
    check_output("t4_rdy_drop", write_req_rdy[0], 0);
    n = 0;
    while (!write_req_rdy[0] && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_output("t4_write_accept", write_req_rdy[0], 1);
    @(posedge clk);
    #1;
    write_req_val[0] = 1'b0;
    wait_drain("t4a");
    send_req(2'd0, 1'b0, 8'h05, 16'h0, 16'h1234);
    wait_drain("t4b");

    $display("[TB] out-of-range address");
    send_req(2'd1, 1'b1, 8'hF0, 16'h7777, 16'h0);
    wait_drain("t5w");
    send_req(2'd1, 1'b0, 8'hF0, 16'h0, 16'h0);
    send_req(2'd1, 1'b0, 8'h70, 16'h0, 16'h0);
    wait_drain("t5r");

    $display("[TB] reset during BUSY");
    write_req_addr[1] = 8'h20;
    write_req_data[1] = 16'h0055;
    write_req_val[1]  = 1'b1;
    @(posedge clk);
    #1;
    write_req_val[1] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("t6");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    send_req(2'd1, 1'b0, 8'h20, 16'h0, 16'h0);
    send_req(2'd2, 1'b0, 8'h10, 16'h0, 16'h0);
    wait_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory responder on the far end of the compute unit's per-thread LSU interface.
- Accepts NUM_THREADS independent load/store request channels and round-robin arbitrates them onto a single-port internal word array with MEM_LATENCY access delay.
- Returns read data and write acknowledgements on each channel's response wires.
- Sits between cu instances and the testbench/host in the minigpu top level.

Parameters:
- NUM_THREADS, 4, number of LSU channels served
- DATA_WIDTH, 16, memory word width
- DATA_ADDR_WIDTH, 8, word address width
- MEM_DEPTH, 256, number of words; must be ≤ 2**DATA_ADDR_WIDTH
- MEM_LATENCY, 2, cycles spent in BUSY per access; must be ≥1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset (0 = reset asserted)
- read_req_rdy[NUM_THREADS]  out  1 each  channel can accept a read
- read_req_addr[NUM_THREADS]  in  DATA_ADDR_WIDTH each  read address
- read_req_addr_val[NUM_THREADS]  in  1 each  read request valid
- read_resp_rdy[NUM_THREADS]  in  1 each  LSU accepts read data
- read_resp_data[NUM_THREADS]  out  DATA_WIDTH each  read data
- read_resp_data_val[NUM_THREADS]  out  1 each  read data valid
- write_req_rdy[NUM_THREADS]  out  1 each  channel can accept a write
- write_req_addr[NUM_THREADS]  in  DATA_ADDR_WIDTH each  write address
- write_req_data[NUM_THREADS]  in  DATA_WIDTH each  write data
- write_req_val[NUM_THREADS]  in  1 each  write request valid
- write_resp_val[NUM_THREADS]  out  1 each  one-cycle write-done pulse

Behaviour:
- Reset (reset=0, async):
  - All outputs are 0; all pending slots are empty; rr_ptr=0; state=IDLE.
  - The memory array clears to 0.
- Per-channel one-entry pending slot {valid, is_write, addr, data}:
  - read_req_rdy[i] = write_req_rdy[i] = !pending[i].
  - A read is accepted on a rising edge with read_req_addr_val & rdy.
  - A write is accepted on a rising edge with write_req_val & rdy.
  - If both are valid on the same channel in the same cycle, the read is accepted and the write waits (rdy drops next cycle).
- FSM states: IDLE, BUSY, RESP.
  - IDLE: if any slot is pending, grant the first pending channel searching from rr_ptr upward with wrap. Then g<=grant, rr_ptr<=(grant+1)%NUM_THREADS, cnt<=MEM_LATENCY-1, go to BUSY. Otherwise stay in IDLE.
  - BUSY: if cnt==0, perform the access. A write stores data at addr; a read latches mem[addr] into resp_data[g]. Then go to RESP. Otherwise cnt<=cnt-1.
  - RESP, read: read_resp_data_val[g]=1 and data is held stable until read_resp_rdy[g]=1. On that edge, clear val and pending[g], then go to IDLE.
  - RESP, write: write_resp_val[g]=1 for exactly one cycle; clear pending[g], then go to IDLE.
- Timing:
  - Accept at edge E0 → BUSY at E1 → RESP at E(1+MEM_LATENCY).
  - Minimum request-to-response is MEM_LATENCY+1 cycles; one access completes at a time.
- Out-of-range addr (≥MEM_DEPTH): reads return 0, writes are dropped, and the response is still produced normally.
- A request arriving on a channel in the same cycle as that channel's response completion is not accepted (rdy is still 0); it is accepted the next cycle.
- Reset asserted mid-access: the access is abandoned immediately, no partial write occurs, and all state returns to reset values.
- Fairness: with all channels continuously pending, grants rotate 0,1,2,3,0,...

Optional Feature:
- Macro DMEM_CTRL_HOST_PORT_EN.
- When defined, adds ports:
  - host_we in 1
  - host_addr in DATA_ADDR_WIDTH
  - host_wdata in DATA_WIDTH
  - host_rdata out DATA_WIDTH, combinational mem[host_addr]; 0 if out of range
- host_we writes the array on the clock edge.
- While host_we=1, the IDLE state does not grant (host has priority). BUSY/RESP are unaffected.
- If a host write and a BUSY-completing LSU write target the same address in the same cycle, the host value wins.
- When undefined, none of these ports exist and the array is reachable only through the LSU channels.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, BUSY, RESP}
  - THREAD_IDX_WIDTH = $clog2(NUM_THREADS)
  - pending-slot struct
- Sub-module rr_arbiter:
  - inputs: request vector, rr_ptr
  - outputs: grant index, any_grant
  - combinational; parameterised on NUM_THREADS

Test Plan:
1. Single write then read, MEM_LATENCY=2. Ch1 writes 0xBEEF to addr 0x10 → write_resp_val[1] pulses 3 cycles after accept. Ch1 then reads 0x10 → read_resp_data[1]=0xBEEF with val 3 cycles after accept.
2. Contention. All 4 channels read addr 0x00–0x03 (preloaded 0xA0..0xA3) in the same cycle → responses in order ch0,1,2,3, each with correct data; rdy for each channel stays 0 until its own response completes.
3. Backpressure. read_resp_rdy[2]=0 for 5 cycles → data/val are held stable and no other grant occurs; on rdy=1, completes and FSM returns to IDLE.
4. Simultaneous read+write on ch0 (read 0x05, write 0x05←0x1234) → read serviced first returning old value 0; write accepted afterward; a subsequent read returns 0x1234.
5. Out-of-range address with MEM_DEPTH=128, addr 0xF0 → write dropped with pulse still issued; read returns 0 with val.
6. Reset pulled low during BUSY of a write 0x55→addr 0x20 → all outputs are 0 immediately; after release, a read of 0x20 returns 0.
